uart_mmio_responder: RTL



---
 rtl/uart_mmio_pkg.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_mmio_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO responder: register offsets, STATUS bit positions, TX FSM states.
// Latency: none, this file holds only constants, types and a pure function.
// Backpressure: not applicable.
package uart_mmio_pkg;

    // Register offsets from the window base address
    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_IE     = 32'h0000_0001;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0005;
    localparam logic [31:0] OFF_BAUD   = 32'h0000_0100;

    // STATUS register bit positions
    localparam int ST_RX_READY = 0;
    localparam int ST_OVERRUN  = 1;
    localparam int ST_TX_EMPTY = 5;
    localparam int ST_TX_BUSY  = 6;

    // Transmit handshake states
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        START,
        WAIT
    } tx_state_t;

    // Pack the individual status flags into the 32-bit STATUS word
    function automatic logic [31:0] status_word(input logic rx_ready,
                                                input logic overrun,
                                                input logic tx_empty,
                                                input logic tx_busy);
        logic [31:0] w;
        w              = '0;
        w[ST_RX_READY] = rx_ready;
        w[ST_OVERRUN]  = overrun;
        w[ST_TX_EMPTY] = tx_empty;
        w[ST_TX_BUSY]  = tx_busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO buffering received UART bytes until the core reads them.
// Latency: a pushed byte is visible at head the cycle after the push.
// Backpressure: none upstream; a push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop_ok;
    logic          push_ok;

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign head  = mem[rptr];

    // Storage array, no reset needed since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// MMIO responder for the UART pair: DATA/STATUS/BAUD registers, RX byte FIFO, TX handshake FSM. Optional UART_IRQ_EN adds IE register and irq.
// Latency: load response one cycle after read_enable; tx_start two cycles after an accepted DATA write when the transmitter is idle.
// Backpressure: DATA writes while a byte is in flight are dropped; RX bytes arriving with the FIFO full are dropped and flagged as overrun.
module uart_mmio_responder
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          RX_DEPTH   = 4,
    parameter logic [15:0] BAUD_RESET = 16'h0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_max,
    output logic        hit
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        sel_data;
    logic        sel_status;
    logic        sel_baud;
    logic        sel_ie;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] rd_mux;

    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        rx_empty;
    logic        rx_full;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic        rx_ready;
    logic        overrun;
    logic        overrun_evt;

    tx_state_t   tx_state;
    logic        busy_seen;
    logic        tx_empty;

    logic        unused_bits;

    // Exact-address decode of the register window
    assign sel_data   = (address == BASE_ADDR + OFF_DATA);
    assign sel_status = (address == BASE_ADDR + OFF_STATUS);
    assign sel_baud   = (address == BASE_ADDR + OFF_BAUD);
`ifdef UART_IRQ_EN
    assign sel_ie     = (address == BASE_ADDR + OFF_IE);
`else
    assign sel_ie     = 1'b0;
`endif
    assign hit = sel_data | sel_status | sel_baud | sel_ie;

    // A store wins over a simultaneous load
    assign wr_req = write_enable & hit;
    assign rd_req = read_enable & hit & ~write_enable;

    assign rx_pop      = rd_req & sel_data & ~rx_empty;
    assign rx_ready    = (rx_count != '0);
    assign overrun_evt = rx_valid & rx_full & ~rx_pop;
    assign tx_empty    = (tx_state == IDLE);

    assign unused_bits = ^{write_data[31:16], write_mask[3:2]};

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

`ifdef UART_IRQ_EN
    logic [1:0] ie;

    // Interrupt enable register and registered interrupt line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie  <= 2'b00;
            irq <= 1'b0;
        end else begin
            if (wr_req && sel_ie && write_mask[0]) begin
                ie <= write_data[1:0];
            end
            irq <= (ie[0] & rx_ready) | (ie[1] & tx_empty);
        end
    end
`endif

    // Load data mux; DATA on an empty FIFO reads as zero
    always_comb begin
        rd_mux = '0;
        if (sel_data) begin
            rd_mux = rx_empty ? 32'h0 : {24'h0, rx_head};
        end else if (sel_status) begin
            rd_mux = status_word(rx_ready, overrun, tx_empty, tx_busy);
        end else if (sel_baud) begin
            rd_mux = {16'h0, baud_max};
`ifdef UART_IRQ_EN
        end else if (sel_ie) begin
            rd_mux = {30'h0, ie};
`endif
        end
    end

    // Registered single-cycle load response, data forced to zero when not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= rd_req;
            read_data  <= rd_req ? rd_mux : 32'h0;
        end
    end

    // Sticky overrun flag: cleared by a STATUS read unless a new overrun lands the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (overrun_evt) begin
            overrun <= 1'b1;
        end else if (rd_req && sel_status) begin
            overrun <= 1'b0;
        end
    end

    // Baud divisor with byte-masked writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_max <= BAUD_RESET;
        end else if (wr_req && sel_baud) begin
            if (write_mask[0]) begin
                baud_max[7:0] <= write_data[7:0];
            end
            if (write_mask[1]) begin
                baud_max[15:8] <= write_data[15:8];
            end
        end
    end

    // TX handshake: hold the byte until the transmitter is free, pulse tx_start, then wait for busy to rise and fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= IDLE;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (wr_req && sel_data && write_mask[0]) begin
                        tx_data  <= write_data[7:0];
                        tx_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_state <= START;
                    end
                end
                START: begin
                    tx_start  <= 1'b0;
                    busy_seen <= 1'b0;
                    tx_state  <= WAIT;
                end
                WAIT: begin
                    if (tx_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        tx_state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    tx_state <= IDLE;
                end
            endcase
        end
    end

endmodule
